// File: rtl/l2_mem_responder.sv
// l2_mem_responder: fixed-latency line-granular backing memory for an L2 cache,
// serving one read or write at a time with protocol-error and completion counters.
module l2_mem_responder #(
    parameter int LINES   = 16,
    parameter int LATENCY = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  dfp_addr,
    input  logic         dfp_read,
    input  logic         dfp_write,
    input  logic [255:0] dfp_wdata,
    output logic [255:0] dfp_rdata,
    output logic         dfp_resp,
    output logic         busy,
    output logic         proto_err,
    output logic [15:0]  rd_count,
    output logic [15:0]  wr_count
);
    localparam int IW = $clog2(LINES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         r_state, w_next;
    logic [7:0]     r_cnt;
    logic           r_wr;
    logic [IW-1:0]  r_idx;
    logic [255:0]   r_wdata;
    logic [255:0]   r_mem [LINES];
    logic           r_perr;
    logic [15:0]    r_rd_cnt, r_wr_cnt;
    logic           w_cap;
    logic           w_unused;

    // Address bits outside the line index only alias onto the same storage.
    assign w_unused  = ^{dfp_addr[31:5+IW], dfp_addr[4:0]};
    assign w_cap     = (r_state == IDLE) && (dfp_read ^ dfp_write);
    assign proto_err = r_perr;
    assign rd_count  = r_rd_cnt;
    assign wr_count  = r_wr_cnt;

    always_comb begin
        w_next    = r_state;
        dfp_resp  = r_state == RESP;
        busy      = r_state != IDLE;
        dfp_rdata = (r_state == RESP && !r_wr) ? r_mem[r_idx] : '0;
        if (w_cap)
            w_next = (LATENCY == 1) ? RESP : WAIT;
        else if (r_state == WAIT && r_cnt == 8'd1)
            w_next = RESP;
        else if (r_state == RESP)
            w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_wr     <= 1'b0;
            r_idx    <= '0;
            r_wdata  <= '0;
            r_perr   <= 1'b0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            for (int i = 0; i < LINES; i++)
                r_mem[i] <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cap ? 8'(LATENCY - 1) : (r_state == WAIT ? r_cnt - 8'd1 : r_cnt);
            if (w_cap) begin
                r_wr    <= dfp_write;
                r_idx   <= dfp_addr[5+IW-1:5];
                r_wdata <= dfp_wdata;
            end
            if (dfp_read && dfp_write)
                r_perr <= 1'b1;
            if (r_state == RESP) begin
                if (r_wr) begin
                    r_mem[r_idx] <= r_wdata;
                    if (r_wr_cnt != 16'hFFFF)
                        r_wr_cnt <= r_wr_cnt + 16'd1;
                end else if (r_rd_cnt != 16'hFFFF) begin
                    r_rd_cnt <= r_rd_cnt + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_l2_mem_responder.sv
// tb_l2_mem_responder: directed and randomized checks of l2_mem_responder against
// a line-array reference model (default instance plus a LATENCY=1 instance).
module tb_l2_mem_responder;
    localparam int LAT = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  addr = '0, addr1 = '0;
    logic         rd = 1'b0, wr = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
    logic [255:0] wdata = '0, wdata1 = '0, rdata, rdata1;
    logic         resp, busy, perr, resp1, busy1, perr1;
    logic [15:0]  rc, wc, rc1, wc1;

    int           checks = 0;
    int           errors = 0;
    logic [255:0] mem_m [16];
    int           rd_m = 0, wr_m = 0;
    logic         err_m = 1'b0;

    always #5 clk = ~clk;

    l2_mem_responder u_dut (
        .clk(clk), .rst(rst), .dfp_addr(addr), .dfp_read(rd), .dfp_write(wr),
        .dfp_wdata(wdata), .dfp_rdata(rdata), .dfp_resp(resp), .busy(busy),
        .proto_err(perr), .rd_count(rc), .wr_count(wc)
    );

    l2_mem_responder #(.LINES(4), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .dfp_addr(addr1), .dfp_read(rd1), .dfp_write(wr1),
        .dfp_wdata(wdata1), .dfp_rdata(rdata1), .dfp_resp(resp1), .busy(busy1),
        .proto_err(perr1), .rd_count(rc1), .wr_count(wc1)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++)
            v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++)
            mem_m[i] = '0;
        rd_m  = 0;
        wr_m  = 0;
        err_m = 1'b0;
    endtask

    task automatic chk_counts();
        chk("rd_count", 256'(rc), 256'(rd_m));
        chk("wr_count", 256'(wc), 256'(wr_m));
        chk("proto_err", 256'(perr), 256'(err_m));
    endtask

    // Issue one request in cycle 0 (DUT idle) and check every cycle through completion;
    // while the request is pending, inputs are sometimes scrambled to prove they are ignored.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [255:0] d, input logic scramble);
        logic [255:0] exp_rd;
        exp_rd = w ? '0 : mem_m[a[8:5]];
        rd = !w; wr = w; addr = a; wdata = d;
        for (int k = 0; k <= LAT + 1; k++) begin
            if (k > 0) tick();
            chk("resp", 256'(resp), 256'(k == LAT));
            chk("busy", 256'(busy), 256'(k >= 1 && k <= LAT));
            chk("rdata", rdata, (k == LAT) ? exp_rd : '0);
            if (scramble && k >= 1 && k < LAT && $urandom_range(0, 2) == 0) begin
                rd    = 1'($urandom_range(0, 1));
                wr    = 1'($urandom_range(0, 1));
                addr  = $urandom;
                wdata = rnd256();
                err_m = err_m | (rd & wr);
            end
            if (k == LAT) begin
                rd = 1'b0;
                wr = 1'b0;
            end
        end
        if (w) begin
            mem_m[a[8:5]] = d;
            wr_m++;
        end else begin
            rd_m++;
        end
        chk_counts();
    endtask

    initial begin
        logic [255:0] dat_a, dat_b, d;
        logic [31:0]  a;
        model_reset();
        tick();
        chk("rst_resp", 256'(resp), '0);
        chk("rst_busy", 256'(busy), '0);
        chk("rst_rdata", rdata, '0);
        chk_counts();
        tick();
        rst = 1'b1;

        // Read of never-written line right after reset.
        do_req(1'b0, 32'h0000_0040, '0, 1'b0);
        chk("first_read_cnt", 256'(rc), 256'd1);

        do_req(1'b1, 32'h0000_0060, {8{32'hDEAD_BEEF}}, 1'b0);
        do_req(1'b0, 32'h0000_0060, '0, 1'b0);
        chk("wr_then_rd_wc", 256'(wc), 256'd1);

        dat_a = rnd256();
        do_req(1'b1, 32'h0000_0020, dat_a, 1'b0);
        do_req(1'b0, 32'h0000_0220, '0, 1'b0);

        // Both request lines high while idle: no capture, sticky error.
        rd = 1'b1; wr = 1'b1; addr = 32'h0000_0040;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("both_resp", 256'(resp), '0);
            chk("both_busy", 256'(busy), '0);
            chk("both_perr", 256'(perr), 256'd1);
        end
        rd = 1'b0; wr = 1'b0; err_m = 1'b1;
        tick();
        chk("perr_sticky", 256'(perr), 256'd1);
        chk("both_no_resp", 256'(resp), '0);
        do_req(1'b0, 32'h0000_0060, '0, 1'b0);

        // Reset mid-write aborts it without committing the data.
        dat_b = rnd256();
        wr = 1'b1; addr = 32'h0000_0040; wdata = dat_b;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_busy", 256'(busy), 256'd1);
        end
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("abort_busy0", 256'(busy), '0);
        chk("abort_resp", 256'(resp), '0);
        chk_counts();
        tick();
        chk("abort_resp2", 256'(resp), '0);
        wr = 1'b0;
        rst = 1'b1;
        do_req(1'b0, 32'h0000_0040, '0, 1'b0);

        // Randomized traffic with idle gaps and scrambled inputs while pending.
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            d = rnd256();
            do_req(1'($urandom_range(0, 1)), a, d, 1'b1);
            for (int g = $urandom_range(0, 2); g > 0; g--)
                tick();
        end

        // LATENCY=1 instance with a read held one cycle past its response.
        rd1 = 1'b1; addr1 = 32'h0000_0020;
        chk("l1_c0_resp", 256'(resp1), '0);
        tick();
        chk("l1_c1_resp", 256'(resp1), 256'd1);
        chk("l1_c1_busy", 256'(busy1), 256'd1);
        chk("l1_c1_rdata", rdata1, '0);
        tick();
        chk("l1_c2_resp", 256'(resp1), '0);
        chk("l1_c2_busy", 256'(busy1), '0);
        tick();
        chk("l1_c3_resp", 256'(resp1), 256'd1);
        rd1 = 1'b0;
        tick();
        chk("l1_c4_resp", 256'(resp1), '0);
        chk("l1_rd_count", 256'(rc1), 256'd2);
        chk("l1_wr_count", 256'(wc1), '0);
        chk("l1_perr", 256'(perr1), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
